// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single cache/memory port: fetch (m0) and LSU (m1) share s_*,
// with an in-order tag FIFO that routes read responses back to their issuer.
// Build option: define ARB_RR_EN for round-robin arbitration (default is fixed priority, m1 first).
module mem_port_arbiter #(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 32,
  parameter int BE_W      = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_read,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdata_valid,
  input  logic              m0_flush,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [BE_W-1:0]   m1_byte_en,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_read,
  input  logic              m1_write,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdata_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [BE_W-1:0]   s_byte_en,
  output logic [DATA_W-1:0] s_writedata,
  output logic              s_read,
  output logic              s_write,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_readdata_valid,
  input  logic              s_waitrequest,
  output logic              err_o
);

  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  // Tag FIFO: one {id, drop} pair per slot, kept in flops so flush can touch every slot at once.
  logic [MAX_OUTST-1:0] id_reg;
  logic [MAX_OUTST-1:0] id_next;
  logic [MAX_OUTST-1:0] drop_reg;
  logic [MAX_OUTST-1:0] drop_next;
  logic [PTR_W-1:0]     head_reg;
  logic [PTR_W-1:0]     tail_reg;
  logic [CNT_W-1:0]     count_reg;
  logic                 err_reg;

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic room;
  logic issue0;
  logic issue1;
  logic grant0;
  logic grant1;
  logic accept;
  logic push;
  logic head_id;
  logic head_drop;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_MAX);
  assign head_id    = id_reg[head_reg];
  assign head_drop  = drop_reg[head_reg];

  assign pop  = ~rst & s_readdata_valid & ~fifo_empty;
  // A response leaving this cycle frees a slot for a read issued in the same cycle.
  assign room = ~fifo_full | pop;

  assign issue0 = ~rst & m0_read & room;
  assign issue1 = ~rst & (m1_write | (m1_read & room));

`ifdef ARB_RR_EN
  logic rr_reg;  // master preferred at the next contention

  assign grant1 = issue1 & (~issue0 | rr_reg);
  assign grant0 = issue0 & (~issue1 | ~rr_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_reg <= 1'b0;
    end else if (accept) begin
      rr_reg <= grant0;
    end
  end
`else
  assign grant1 = issue1;
  assign grant0 = issue0 & ~issue1;
`endif

  assign accept = (grant0 | grant1) & ~s_waitrequest;
  assign push   = accept & (grant0 | (grant1 & m1_read));

  always_comb begin
    s_addr         = '0;
    s_byte_en      = '0;
    s_writedata    = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (grant1) begin
      s_addr         = m1_addr;
      s_byte_en      = m1_byte_en;
      s_writedata    = m1_writedata;
      s_read         = m1_read;
      s_write        = m1_write;
      m1_waitrequest = s_waitrequest;
    end else if (grant0) begin
      s_addr         = m0_addr;
      s_byte_en      = '1;
      s_read         = 1'b1;
      m0_waitrequest = s_waitrequest;
    end
  end

  assign m0_readdata       = s_readdata;
  assign m1_readdata       = s_readdata;
  assign m0_readdata_valid = pop & ~head_id & ~head_drop;
  assign m1_readdata_valid = pop & head_id;
  assign err_o             = err_reg;

  // A fetch read accepted together with a flush is born already dropped.
  for (genvar gi = 0; gi < MAX_OUTST; gi++) begin : g_slot
    logic write_slot;
    assign write_slot = push & (tail_reg == PTR_W'(gi));

    always_comb begin
      id_next[gi]   = id_reg[gi];
      drop_next[gi] = drop_reg[gi];
      if (write_slot) begin
        id_next[gi]   = grant1;
        drop_next[gi] = grant0 & m0_flush;
      end else if (m0_flush & ~id_reg[gi]) begin
        drop_next[gi] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_reg    <= '0;
      drop_reg  <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      id_reg   <= id_next;
      drop_reg <= drop_next;
      if (push) begin
        tail_reg <= tail_reg + 1'b1;
      end
      if (pop) begin
        head_reg <= head_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (s_readdata_valid & fifo_empty) begin
        err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all checked per cycle
// against a queue-based reference model of the arbiter's rules.
module tb_mem_port_arbiter;

  localparam int ADDR_W    = 25;
  localparam int DATA_W    = 32;
  localparam int BE_W      = 4;
  localparam int MAX_OUTST = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_read;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdata_valid;
  logic              m0_flush;
  logic [ADDR_W-1:0] m1_addr;
  logic [BE_W-1:0]   m1_byte_en;
  logic [DATA_W-1:0] m1_writedata;
  logic              m1_read;
  logic              m1_write;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdata_valid;
  logic [ADDR_W-1:0] s_addr;
  logic [BE_W-1:0]   s_byte_en;
  logic [DATA_W-1:0] s_writedata;
  logic              s_read;
  logic              s_write;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdata_valid;
  logic              s_waitrequest;
  logic              err_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdata_valid(m0_readdata_valid), .m0_flush(m0_flush),
    .m1_addr(m1_addr), .m1_byte_en(m1_byte_en), .m1_writedata(m1_writedata),
    .m1_read(m1_read), .m1_write(m1_write), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdata_valid(m1_readdata_valid),
    .s_addr(s_addr), .s_byte_en(s_byte_en), .s_writedata(s_writedata),
    .s_read(s_read), .s_write(s_write), .s_readdata(s_readdata),
    .s_readdata_valid(s_readdata_valid), .s_waitrequest(s_waitrequest), .err_o(err_o)
  );

  // Reference model: outstanding reads in issue order, sticky error, next preferred master.
  typedef struct {
    bit id;
    bit drop;
  } entry_t;

  entry_t q[$];
  bit     err_m  = 1'b0;
`ifdef ARB_RR_EN
  bit     pref_m = 1'b0;
`endif
  int     n_checks = 0;
  int     n_pass   = 0;
  int     cyc      = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic idle();
    m0_read = 0; m1_read = 0; m1_write = 0; m0_flush = 0;
    s_readdata_valid = 0; s_waitrequest = 0;
  endtask

  // Check the current cycle's outputs at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    bit popping, room, ok0, ok1, acc;
    int win;
    entry_t h, e;
    @(negedge clk);
    popping = !rst && s_readdata_valid && q.size() > 0;
    room    = (q.size() < MAX_OUTST) || popping;
    ok0     = !rst && m0_read && room;
    ok1     = !rst && (m1_write || (m1_read && room));
    if (ok0 && ok1) begin
`ifdef ARB_RR_EN
      win = pref_m ? 1 : 0;
`else
      win = 1;
`endif
    end else if (ok1) win = 1;
    else if (ok0) win = 0;
    else win = -1;

    check_eq("s_read", s_read, (win == 0) || (win == 1 && m1_read));
    check_eq("s_write", s_write, (win == 1) && m1_write);
    check_eq("s_addr", s_addr, (win == 0) ? m0_addr : (win == 1) ? m1_addr : '0);
    if (win == 1) begin
      check_eq("s_byte_en", s_byte_en, m1_byte_en);
      check_eq("s_writedata", s_writedata, m1_writedata);
    end else if (win == -1) begin
      check_eq("s_byte_en_idle", s_byte_en, 0);
      check_eq("s_writedata_idle", s_writedata, 0);
    end
    check_eq("m0_waitrequest", m0_waitrequest, (win == 0) ? s_waitrequest : 1'b1);
    check_eq("m1_waitrequest", m1_waitrequest, (win == 1) ? s_waitrequest : 1'b1);
    h = '{id: 1'b0, drop: 1'b0};
    if (popping) h = q[0];
    check_eq("m0_readdata_valid", m0_readdata_valid, popping && !h.id && !h.drop);
    check_eq("m1_readdata_valid", m1_readdata_valid, popping && h.id);
    check_eq("m0_readdata", m0_readdata, s_readdata);
    check_eq("m1_readdata", m1_readdata, s_readdata);
    check_eq("err_o", err_o, err_m);

    acc = (win >= 0) && !s_waitrequest;
    if (acc)
      $display("cycle %0d: m%0d %s addr 0x%0h", cyc, win, (win == 1 && m1_write) ? "write" : "read",
               (win == 1) ? m1_addr : m0_addr);
    if (popping)
      $display("cycle %0d: response 0x%0h -> %s", cyc, s_readdata,
               h.id ? "m1" : (h.drop ? "dropped" : "m0"));

    @(posedge clk);
    if (rst) begin
      q.delete();
      err_m = 1'b0;
`ifdef ARB_RR_EN
      pref_m = 1'b0;
`endif
    end else begin
      if (s_readdata_valid && q.size() == 0) err_m = 1'b1;
      if (popping) void'(q.pop_front());
      if (m0_flush) foreach (q[i]) if (!q[i].id) q[i].drop = 1'b1;
      if (acc && (win == 0 || m1_read)) begin
        e.id   = (win == 1);
        e.drop = (win == 0) && m0_flush;
        q.push_back(e);
      end
`ifdef ARB_RR_EN
      if (acc) pref_m = (win == 0);
`endif
    end
    cyc++;
    #1;
  endtask

  task automatic respond(input logic [DATA_W-1:0] data);
    s_readdata_valid = 1; s_readdata = data;
    cycle();
    s_readdata_valid = 0;
  endtask

  task automatic drain();
    int guard = 0;
    idle();
    while (q.size() > 0 && guard < 32) begin
      respond($urandom);
      guard++;
    end
    if (q.size() != 0) check_eq("drain_bound", q.size(), 0);
  endtask

  initial begin
    rst = 1; idle();
    m0_addr = '0; m1_addr = '0; m1_byte_en = '0; m1_writedata = '0; s_readdata = '0;
    @(posedge clk); #1;

    // Reset held with a pending fetch, then the fetch goes straight out.
    m0_read = 1; m0_addr = 25'h10;
    repeat (3) cycle();
    rst = 0;
    cycle();
    drain();

    // Contention between both masters, then two in-order responses.
    m0_read = 1; m0_addr = 25'h20; m1_read = 1; m1_addr = 25'h40;
    cycle();
    m1_read = 0;
    cycle();
    idle();
    respond(32'hD1D1_D1D1);
    respond(32'hD2D2_D2D2);
    drain();

    // Fill the tag FIFO, stall the fifth read, then release it with a response.
    for (int i = 0; i < 4; i++) begin
      m0_read = 1; m0_addr = ADDR_W'(32'h100 + i * 4);
      cycle();
    end
    m0_addr = 25'h110;
    cycle();
    s_readdata_valid = 1; s_readdata = 32'h1234_5678;
    cycle();
    drain();

    // Flush with fetch, LSU, fetch outstanding.
    m0_read = 1; m0_addr = 25'h200; cycle();
    m0_read = 0; m1_read = 1; m1_addr = 25'h300; cycle();
    m1_read = 0; m0_read = 1; m0_addr = 25'h204; cycle();
    idle(); m0_flush = 1; cycle();
    m0_flush = 0;
    respond(32'hAAAA_0001);
    respond(32'hBBBB_0002);
    respond(32'hAAAA_0003);
    drain();

    // Write passthrough with a two-cycle slave stall.
    m1_write = 1; m1_addr = 25'h400; m1_byte_en = 4'b0011; m1_writedata = 32'hDEAD_BEEF;
    s_waitrequest = 1;
    repeat (2) cycle();
    s_waitrequest = 0;
    cycle();
    idle(); cycle();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      int op;
      rst = ($urandom_range(63) == 0);
      op = $urandom_range(3);
      m0_read = $urandom_range(1); m0_addr = ADDR_W'($urandom);
      m1_read = (op == 1); m1_write = (op == 2);
      m1_addr = ADDR_W'($urandom); m1_byte_en = BE_W'($urandom); m1_writedata = $urandom;
      m0_flush = ($urandom_range(15) == 0);
      s_waitrequest = ($urandom_range(3) == 0);
      s_readdata_valid = !rst && q.size() > 0 && $urandom_range(1);
      s_readdata = $urandom;
      cycle();
    end
    rst = 0;
    drain();

    // Both masters requesting continuously.
    for (int i = 0; i < 8; i++) begin
      m0_read = 1; m0_addr = ADDR_W'(32'h500 + i); m1_read = 1; m1_addr = ADDR_W'(32'h600 + i);
      s_readdata_valid = q.size() > 0; s_readdata = $urandom;
      cycle();
    end
    drain();

    // Response with nothing outstanding: sticky error.
    respond(32'hEEEE_EEEE);
    idle();
    repeat (3) cycle();
    @(negedge clk);
    check_eq("err_sticky", err_o, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
